// File: rtl/morse_pkg.sv
// Shared types, constants and the dot/dash pattern builder for the Morse encoder.
// The LOWERCASE_FOLD_EN macro (used in morse_rom) selects lowercase folding.
package morse_pkg;

  localparam int unsigned MORSE_BITS     = 20;
  localparam int unsigned CODE_WIDTH_DEF = MORSE_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_RDY, PRESENT} state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_Z     = 8'h5A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LZ    = 8'h7A;

  localparam logic [1:0] DOT  = 2'b10;
  localparam logic [3:0] DASH = 4'b1110;

  // Symbol count plus symbols right-aligned, first symbol at bit len-1 (1 = dash)
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] sym;
  } morse_sym_t;

  function automatic logic [MORSE_BITS-1:0] morse_expand(input morse_sym_t s);
    logic [MORSE_BITS-1:0] acc;
    logic [4:0]            sh;
    int unsigned           nbits;
    acc   = '0;
    nbits = 0;
    sh    = s.sym << (3'd5 - s.len);
    for (int unsigned k = 0; k < 5; k++) begin
      if (k < 32'(s.len)) begin
        if (sh[4]) begin
          acc   = {acc[MORSE_BITS-5:0], DASH};
          nbits = nbits + 4;
        end else begin
          acc   = {acc[MORSE_BITS-3:0], DOT};
          nbits = nbits + 2;
        end
      end
      sh = {sh[3:0], 1'b0};
    end
    return acc << (MORSE_BITS - nbits);
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational ASCII-to-Morse lookup producing a left-aligned on/off pattern.
// LOWERCASE_FOLD_EN: when defined, 'a'-'z' fold to uppercase before lookup.
module morse_rom
  import morse_pkg::*;
#(
  parameter int unsigned CODE_WIDTH = CODE_WIDTH_DEF
) (
  input  logic [7:0]            char_i,
  output logic [CODE_WIDTH-1:0] code_o,
  output logic                  is_space_o,
  output logic                  valid_o
);

  logic [7:0] ch;
  morse_sym_t ent;

  always_comb begin
    ch = char_i;
`ifdef LOWERCASE_FOLD_EN
    if (char_i >= ASCII_LA && char_i <= ASCII_LZ) ch = char_i - 8'h20;
`endif
    ent        = '0;
    is_space_o = 1'b0;
    case (ch)
      ASCII_SPACE: is_space_o = 1'b1;
      ASCII_A: ent = {3'd2, 5'b00001};
      8'h42:   ent = {3'd4, 5'b01000};
      8'h43:   ent = {3'd4, 5'b01010};
      8'h44:   ent = {3'd3, 5'b00100};
      8'h45:   ent = {3'd1, 5'b00000};
      8'h46:   ent = {3'd4, 5'b00010};
      8'h47:   ent = {3'd3, 5'b00110};
      8'h48:   ent = {3'd4, 5'b00000};
      8'h49:   ent = {3'd2, 5'b00000};
      8'h4A:   ent = {3'd4, 5'b00111};
      8'h4B:   ent = {3'd3, 5'b00101};
      8'h4C:   ent = {3'd4, 5'b00100};
      8'h4D:   ent = {3'd2, 5'b00011};
      8'h4E:   ent = {3'd2, 5'b00010};
      8'h4F:   ent = {3'd3, 5'b00111};
      8'h50:   ent = {3'd4, 5'b00110};
      8'h51:   ent = {3'd4, 5'b01101};
      8'h52:   ent = {3'd3, 5'b00010};
      8'h53:   ent = {3'd3, 5'b00000};
      8'h54:   ent = {3'd1, 5'b00001};
      8'h55:   ent = {3'd3, 5'b00001};
      8'h56:   ent = {3'd4, 5'b00001};
      8'h57:   ent = {3'd3, 5'b00011};
      8'h58:   ent = {3'd4, 5'b01001};
      8'h59:   ent = {3'd4, 5'b01011};
      ASCII_Z: ent = {3'd4, 5'b01100};
      ASCII_0: ent = {3'd5, 5'b11111};
      8'h31:   ent = {3'd5, 5'b01111};
      8'h32:   ent = {3'd5, 5'b00111};
      8'h33:   ent = {3'd5, 5'b00011};
      8'h34:   ent = {3'd5, 5'b00001};
      8'h35:   ent = {3'd5, 5'b00000};
      8'h36:   ent = {3'd5, 5'b10000};
      8'h37:   ent = {3'd5, 5'b11000};
      8'h38:   ent = {3'd5, 5'b11100};
      ASCII_9: ent = {3'd5, 5'b11110};
      default: ent = '0;
    endcase
    valid_o = is_space_o || (ent.len != 3'd0);
    code_o  = CODE_WIDTH'(morse_expand(ent)) << (CODE_WIDTH - MORSE_BITS);
  end

endmodule

// File: rtl/morse_encoder.sv
// Character-to-Morse feeder: accepts ASCII chars, encodes, and loads the blinker.
// Build option LOWERCASE_FOLD_EN enables lowercase folding inside morse_rom.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int unsigned CODE_WIDTH     = CODE_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16000000,
  parameter int unsigned TIMEOUT_WIDTH  = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_char,
  input  logic                  i_char_valid,
  output logic                  o_char_ready,
  input  logic                  i_blink_ready,
  output logic                  o_read,
  output logic [CODE_WIDTH-1:0] o_morse_code,
  output logic                  o_s3,
  output logic                  o_s7,
  output logic                  o_bad_char,
  output logic                  o_timeout
);

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [7:0]              char_q, char_d;
  logic [CODE_WIDTH-1:0]   code_q, code_d;
  logic                    s3_q, s3_d, s7_q, s7_d;
  logic                    seen_q, seen_d, prev_space_q, prev_space_d;
  logic                    read_q, read_d, bad_q, bad_d, tmo_q, tmo_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  logic [CODE_WIDTH-1:0]   rom_code;
  logic                    rom_space, rom_valid;

  morse_rom #(.CODE_WIDTH(CODE_WIDTH)) u_rom (
    .char_i     (char_q),
    .code_o     (rom_code),
    .is_space_o (rom_space),
    .valid_o    (rom_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      char_q       <= '0;
      code_q       <= '0;
      s3_q         <= 1'b0;
      s7_q         <= 1'b0;
      seen_q       <= 1'b0;
      prev_space_q <= 1'b0;
      read_q       <= 1'b0;
      bad_q        <= 1'b0;
      tmo_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      char_q       <= char_d;
      code_q       <= code_d;
      s3_q         <= s3_d;
      s7_q         <= s7_d;
      seen_q       <= seen_d;
      prev_space_q <= prev_space_d;
      read_q       <= read_d;
      bad_q        <= bad_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    char_d       = char_q;
    code_d       = code_q;
    s3_d         = s3_q;
    s7_d         = s7_q;
    seen_d       = seen_q;
    prev_space_d = prev_space_q;
    read_d       = read_q;
    bad_d        = 1'b0;
    tmo_d        = 1'b0;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_char_valid) begin
          char_d  = i_char;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (rom_valid) begin
          code_d       = rom_code;
          s3_d         = !rom_space && seen_q && !prev_space_q;
          s7_d         = rom_space;
          seen_d       = 1'b1;
          prev_space_d = rom_space;
          state_d      = WAIT_RDY;
        end else begin
          bad_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_RDY: begin
        cnt_d = '0;
        if (i_blink_ready) begin
          read_d  = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // A take (ready low) wins over a coincident timeout
        if (!i_blink_ready) begin
          read_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          read_d  = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_RDY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_char_ready = (state_q == IDLE);
  assign o_read       = read_q;
  assign o_morse_code = code_q;
  assign o_s3         = s3_q;
  assign o_s7         = s7_q;
  assign o_bad_char   = bad_q;
  assign o_timeout    = tmo_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder: vector table plus timeout and reset sequences.
module tb_morse_encoder;

  localparam int unsigned CW = 20;

  logic          clk, rst_n;
  logic [7:0]    i_char;
  logic          i_char_valid, i_blink_ready;
  logic          o_char_ready, o_read, o_s3, o_s7, o_bad_char, o_timeout;
  logic [CW-1:0] o_morse_code;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] last_code;

  morse_encoder #(.CODE_WIDTH(CW), .TIMEOUT_CYCLES(8), .TIMEOUT_WIDTH(24)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_char        (i_char),
    .i_char_valid  (i_char_valid),
    .o_char_ready  (o_char_ready),
    .i_blink_ready (i_blink_ready),
    .o_read        (o_read),
    .o_morse_code  (o_morse_code),
    .o_s3          (o_s3),
    .o_s7          (o_s7),
    .o_bad_char    (o_bad_char),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    ch;
    logic          bad;
    logic [CW-1:0] code;
    logic          s3;
    logic          s7;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " char_ready"}, 32'(o_char_ready), 32'(1'b1));
    check({tag, " read"},       32'(o_read),       32'(1'b0));
    check({tag, " code"},       32'(o_morse_code), 32'(0));
    check({tag, " s3"},         32'(o_s3),         32'(1'b0));
    check({tag, " s7"},         32'(o_s7),         32'(1'b0));
    check({tag, " bad"},        32'(o_bad_char),   32'(1'b0));
    check({tag, " timeout"},    32'(o_timeout),    32'(1'b0));
  endtask

  // Entered just after a negedge with the encoder idle and blink ready high
  task automatic run_vec(input vec_t v);
    string t;
    t = $sformatf("chr %02h", v.ch);
    check({t, " char_ready"}, 32'(o_char_ready), 32'(1'b1));
    i_char       = v.ch;
    i_char_valid = 1'b1;
    @(negedge clk);
    i_char_valid = 1'b0;
    check({t, " read in lookup"}, 32'(o_read), 32'(1'b0));
    check({t, " busy in lookup"}, 32'(o_char_ready), 32'(1'b0));
    @(negedge clk);
    if (v.bad) begin
      check({t, " bad pulse"},      32'(o_bad_char),   32'(1'b1));
      check({t, " no read"},        32'(o_read),       32'(1'b0));
      check({t, " ready again"},    32'(o_char_ready), 32'(1'b1));
      check({t, " code unchanged"}, 32'(o_morse_code), 32'(last_code));
      @(negedge clk);
      check({t, " bad one cycle"},  32'(o_bad_char),   32'(1'b0));
      check({t, " still no read"},  32'(o_read),       32'(1'b0));
    end else begin
      check({t, " no bad"},         32'(o_bad_char),   32'(1'b0));
      check({t, " read wait"},      32'(o_read),       32'(1'b0));
      @(negedge clk);
      check({t, " read rise"},      32'(o_read),       32'(1'b1));
      check({t, " code"},           32'(o_morse_code), 32'(v.code));
      check({t, " s3"},             32'(o_s3),         32'(v.s3));
      check({t, " s7"},             32'(o_s7),         32'(v.s7));
      repeat (2) begin
        @(negedge clk);
        check({t, " read hold"},    32'(o_read),       32'(1'b1));
      end
      i_blink_ready = 1'b0;
      @(negedge clk);
      check({t, " read drop"},      32'(o_read),       32'(1'b0));
      check({t, " idle after take"}, 32'(o_char_ready), 32'(1'b1));
      check({t, " code held"},      32'(o_morse_code), 32'(v.code));
      i_blink_ready = 1'b1;
      last_code     = v.code;
    end
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{8'h45, 1'b0, 20'h80000, 1'b0, 1'b0};  // E, first after reset
    vecs[1]  = '{8'h53, 1'b0, 20'hA8000, 1'b1, 1'b0};  // S
    vecs[2]  = '{8'h4F, 1'b0, 20'hEEE00, 1'b1, 1'b0};  // O
    vecs[3]  = '{8'h53, 1'b0, 20'hA8000, 1'b1, 1'b0};  // S
    vecs[4]  = '{8'h41, 1'b0, 20'hB8000, 1'b1, 1'b0};  // A
    vecs[5]  = '{8'h20, 1'b0, 20'h00000, 1'b0, 1'b1};  // space
    vecs[6]  = '{8'h42, 1'b0, 20'hEA800, 1'b0, 1'b0};  // B after word gap
    vecs[7]  = '{8'h30, 1'b0, 20'hEEEEE, 1'b1, 1'b0};  // 0, full width
    vecs[8]  = '{8'h23, 1'b1, 20'h00000, 1'b0, 1'b0};  // #, unsupported
    vecs[9]  = '{8'h39, 1'b0, 20'hEEEE8, 1'b1, 1'b0};  // 9
`ifdef LOWERCASE_FOLD_EN
    vecs[10] = '{8'h71, 1'b0, 20'hEEB80, 1'b1, 1'b0};  // q folds to Q
`else
    vecs[10] = '{8'h71, 1'b1, 20'h00000, 1'b0, 1'b0};  // q rejected
`endif
    vecs[11] = '{8'h20, 1'b0, 20'h00000, 1'b0, 1'b1};
    vecs[12] = '{8'h20, 1'b0, 20'h00000, 1'b0, 1'b1};
    vecs[13] = '{8'h5A, 1'b0, 20'hEEA00, 1'b0, 1'b0};  // Z after spaces

    clk           = 1'b0;
    rst_n         = 1'b0;
    i_char        = 8'h00;
    i_char_valid  = 1'b0;
    i_blink_ready = 1'b1;
    last_code     = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Blinker not ready on arrival, then stalls in PRESENT until timeout and retry
    i_blink_ready = 1'b0;
    i_char        = 8'h54;
    i_char_valid  = 1'b1;
    @(negedge clk);
    i_char_valid = 1'b0;
    @(negedge clk);
    repeat (3) begin
      check("T wait no read", 32'(o_read),       32'(1'b0));
      check("T wait code",    32'(o_morse_code), 32'(20'hE0000));
      @(negedge clk);
    end
    check("T s3", 32'(o_s3), 32'(1'b1));
    check("T s7", 32'(o_s7), 32'(1'b0));
    i_blink_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("T present read k%0d", k), 32'(o_read),    32'(1'b1));
      check($sformatf("T present tmo k%0d", k),  32'(o_timeout), 32'(1'b0));
    end
    @(negedge clk);
    check("T timeout pulse", 32'(o_timeout), 32'(1'b1));
    check("T read dropped",  32'(o_read),    32'(1'b0));
    @(negedge clk);
    check("T timeout cleared", 32'(o_timeout),    32'(1'b0));
    check("T read retry",      32'(o_read),       32'(1'b1));
    check("T retry code",      32'(o_morse_code), 32'(20'hE0000));
    @(negedge clk);

    // Reset mid-PRESENT: outputs return to reset values without waiting for a clock
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    @(negedge clk);
    rst_n     = 1'b1;
    last_code = '0;
    @(negedge clk);
    check("no retry after reset", 32'(o_read), 32'(1'b0));

    v = '{8'h23, 1'b1, 20'h00000, 1'b0, 1'b0};
    run_vec(v);
    v = '{8'h45, 1'b0, 20'h80000, 1'b0, 1'b0};  // history cleared: s3 low
    run_vec(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
